// File: rtl/aes_pkg.sv
// Shared definitions for the AES input loader.
// Contents: loader state encoding, key-length codes, block widths, and a helper
// that maps a key-length code to its number of key bytes.
package aes_pkg;

    localparam int unsigned MSG_W = 128;
    localparam int unsigned KEY_W = 256;

    localparam logic [1:0] KEY128 = 2'b01;
    localparam logic [1:0] KEY192 = 2'b10;
    localparam logic [1:0] KEY256 = 2'b11;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoadMsg = 2'd1,
        StLoadKey = 2'd2,
        StValid   = 2'd3
    } loader_state_t;

    // Number of key bytes for a key-length code. Code 00 never reaches the
    // datapath because a start with key_sel=00 is ignored.
    function automatic logic [5:0] key_bytes(input logic [1:0] code);
        unique case (code)
            KEY192:  key_bytes = 6'd24;
            KEY256:  key_bytes = 6'd32;
            default: key_bytes = 6'd16;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Pushbutton synchronizer and debouncer.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   btn    - raw button level, asynchronous to clk
//   accept - one-cycle pulse at the edge that accepts a debounced press
// A change of the synchronized level is adopted only after it has differed
// from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
module button_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic accept
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q, level_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   btn_sync;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q[0] <= btn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // accept is combinational from registered state only, so the loader FSM
    // acts on the very edge at which the level is adopted.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        accept  = 1'b0;
        if (btn_sync == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d   = '0;
            level_d = btn_sync;
            accept  = btn_sync;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/aes_input_loader.sv
// Assembles a 128-bit plaintext block and a 128/192/256-bit key one byte per
// debounced button press, then offers them over a valid/ready handshake.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   data_in      - byte from switches, captured on each accepted press
//   load_btn     - raw pushbutton (active high, asynchronous)
//   key_sel      - key length code, latched when a block starts
//   block_ready  - consumer accepts the block
//   message      - plaintext, byte 0 in [127:120]
//   key          - key, left-justified, byte 0 in [255:248], unused bytes zero
//   key_len      - latched key_sel
//   block_valid  - block complete and stable
//   busy         - loading message or key
//   byte_count   - bytes captured in the current phase
module aes_input_loader
    import aes_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         data_in,
    input  logic               load_btn,
    input  logic [1:0]         key_sel,
    input  logic               block_ready,
    output logic [MSG_W-1:0]   message,
    output logic [KEY_W-1:0]   key,
    output logic [1:0]         key_len,
    output logic               block_valid,
    output logic               busy,
    output logic [5:0]         byte_count
);

    logic accept;

    button_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (reset),
        .btn    (load_btn),
        .accept (accept)
    );

    loader_state_t    state_q, state_d;
    logic [MSG_W-1:0] message_q, message_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [1:0]       key_len_q, key_len_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [5:0]       count_q, count_d;

    // Bit offsets of byte k: 8*(15-k) and 8*(31-k), i.e. the inverted index.
    logic [6:0] msg_base;
    logic [7:0] key_base;
    assign msg_base = {~count_q[3:0], 3'b000};
    assign key_base = {~count_q[4:0], 3'b000};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            message_q <= '0;
            key_q     <= '0;
            key_len_q <= 2'b00;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            message_q <= message_d;
            key_q     <= key_d;
            key_len_q <= key_len_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        message_d = message_q;
        key_d     = key_q;
        key_len_d = key_len_q;
        valid_d   = valid_q;
        count_d   = count_q;
        unique case (state_q)
            StIdle: begin
                // Previous block stays on display until a new start.
                if (accept && key_sel != 2'b00) begin
                    key_len_d              = key_sel;
                    message_d              = '0;
                    message_d[127:120]     = data_in;
                    key_d                  = '0;
                    count_d                = 6'd1;
                    state_d                = StLoadMsg;
                end
            end
            StLoadMsg: begin
                if (accept) begin
                    message_d[msg_base +: 8] = data_in;
                    if (count_q == 6'd15) begin
                        count_d = 6'd0;
                        state_d = StLoadKey;
                    end else begin
                        count_d = count_q + 6'd1;
                    end
                end
            end
            StLoadKey: begin
                if (accept) begin
                    key_d[key_base +: 8] = data_in;
                    count_d              = count_q + 6'd1;
                    if (count_q == key_bytes(key_len_q) - 6'd1) begin
                        valid_d = 1'b1;
                        state_d = StValid;
                    end
                end
            end
            StValid: begin
                // Presses are ignored here, even on the handshake edge.
                if (block_ready) begin
                    valid_d = 1'b0;
                    count_d = 6'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StLoadMsg) || (state_d == StLoadKey);
    end

    assign message     = message_q;
    assign key         = key_q;
    assign key_len     = key_len_q;
    assign block_valid = valid_q;
    assign busy        = busy_q;
    assign byte_count  = count_q;

endmodule

// File: tb/tb_aes_input_loader.sv
module tb_aes_input_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   data_in = 8'h00;
    logic         load_btn = 1'b0;
    logic [1:0]   key_sel = 2'b00;
    logic         block_ready = 1'b0;
    logic [127:0] message;
    logic [255:0] key;
    logic [1:0]   key_len;
    logic         block_valid;
    logic         busy;
    logic [5:0]   byte_count;

    aes_input_loader #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .load_btn    (load_btn),
        .key_sel     (key_sel),
        .block_ready (block_ready),
        .message     (message),
        .key         (key),
        .key_len     (key_len),
        .block_valid (block_valid),
        .busy        (busy),
        .byte_count  (byte_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] msg;
        logic [255:0] key;
        logic [1:0]   len;
    } blk_t;

    blk_t sb[$];
    int checks = 0;
    int failures = 0;

    logic [7:0] k128 [16] = '{8'h2b, 8'h7e, 8'h15, 8'h16, 8'h28, 8'hae, 8'hd2, 8'ha6,
                              8'hab, 8'hf7, 8'h15, 8'h88, 8'h09, 8'hcf, 8'h4f, 8'h3c};
    logic [7:0] k192 [24] = '{8'h8e, 8'h73, 8'hb0, 8'hf7, 8'hda, 8'h0e, 8'h64, 8'h52,
                              8'hc8, 8'h10, 8'hf3, 8'h2b, 8'h80, 8'h90, 8'h79, 8'he5,
                              8'h62, 8'hf8, 8'hea, 8'hd2, 8'h52, 8'h2c, 8'h6b, 8'h7b};

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: long enough high to be accepted, long enough low to rearm.
    task automatic press(input logic [7:0] b);
        data_in  = b;
        load_btn = 1'b1;
        tick(8);
        load_btn = 1'b0;
        tick(8);
    endtask

    task automatic handshake();
        block_ready = 1'b1;
        tick(1);
        block_ready = 1'b0;
    endtask

    // Wait (bounded) for block_valid, then compare against the scoreboard head.
    task automatic expect_block(input string tag, input int budget);
        int n = 0;
        blk_t e;
        while (block_valid !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_valid"}, {255'd0, block_valid}, 256'd1);
        check({tag, "_sb_nonempty"}, {255'd0, sb.size() != 0}, 256'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_message"}, {128'd0, message}, {128'd0, e.msg});
            check({tag, "_key"}, key, e.key);
            check({tag, "_key_len"}, {254'd0, key_len}, {254'd0, e.len});
        end
    endtask

    function automatic logic [255:0] left_key(input logic [255:0] acc, input int n);
        return acc << (8 * (32 - n));
    endfunction

    initial begin
        blk_t e;
        logic [127:0] saved_msg;
        logic [255:0] saved_key;
        logic [255:0] acc;

        // Reset state
        tick(3);
        check("rst_message", {128'd0, message}, 256'd0);
        check("rst_key", key, 256'd0);
        check("rst_key_len", {254'd0, key_len}, 256'd0);
        check("rst_valid", {255'd0, block_valid}, 256'd0);
        check("rst_busy", {255'd0, busy}, 256'd0);
        check("rst_count", {250'd0, byte_count}, 256'd0);
        reset = 1'b1;
        tick(2);

        // 128-bit load
        key_sel = 2'b01;
        e.msg = 128'h00112233445566778899aabbccddeeff;
        acc = '0;
        for (int i = 0; i < 16; i++) acc = {acc[247:0], k128[i]};
        e.key = left_key(acc, 16);
        e.len = 2'b01;
        sb.push_back(e);
        press(8'h00);
        check("k128_first_busy", {255'd0, busy}, 256'd1);
        check("k128_first_count", {250'd0, byte_count}, 256'd1);
        for (int i = 1; i < 16; i++) press(8'(i * 8'h11));
        check("k128_msgdone_count", {250'd0, byte_count}, 256'd0);
        check("k128_msgdone_busy", {255'd0, busy}, 256'd1);
        for (int i = 0; i < 16; i++) press(k128[i]);
        expect_block("k128", 40);
        check("k128_count", {250'd0, byte_count}, 256'd16);
        check("k128_busy", {255'd0, busy}, 256'd0);
        saved_msg = message;
        saved_key = key;
        tick(20);
        check("k128_hold_valid", {255'd0, block_valid}, 256'd1);
        handshake();
        check("k128_hs_valid", {255'd0, block_valid}, 256'd0);
        check("k128_hs_count", {250'd0, byte_count}, 256'd0);
        check("k128_hs_message", {128'd0, message}, {128'd0, saved_msg});
        check("k128_hs_key", key, saved_key);

        // 192-bit load
        key_sel = 2'b10;
        e.msg = '0;
        for (int i = 0; i < 16; i++) e.msg = {e.msg[119:0], 8'(8'h31 + 8'(i * 7))};
        acc = '0;
        for (int i = 0; i < 24; i++) acc = {acc[247:0], k192[i]};
        e.key = left_key(acc, 24);
        e.len = 2'b10;
        sb.push_back(e);
        for (int i = 0; i < 16; i++) press(8'(8'h31 + 8'(i * 7)));
        for (int i = 0; i < 23; i++) press(k192[i]);
        check("k192_not_yet_valid", {255'd0, block_valid}, 256'd0);
        press(k192[23]);
        expect_block("k192", 40);
        check("k192_low_zero", {192'd0, key[63:0]}, 256'd0);
        check("k192_count", {250'd0, byte_count}, 256'd24);
        handshake();
        check("k192_hs_valid", {255'd0, block_valid}, 256'd0);

        // Glitch shorter than the debounce window
        key_sel = 2'b01;
        data_in = 8'h5a;
        load_btn = 1'b1;
        tick(3);
        load_btn = 1'b0;
        tick(10);
        check("glitch_count", {250'd0, byte_count}, 256'd0);
        check("glitch_busy", {255'd0, busy}, 256'd0);

        // Bouncing press: one accept, exactly 2+4 edges after the final rise
        for (int i = 0; i < 2; i++) begin
            load_btn = 1'b1;
            tick(2);
            load_btn = 1'b0;
            tick(2);
        end
        tick(2);
        load_btn = 1'b1;
        tick(5);
        check("bounce_edge5_count", {250'd0, byte_count}, 256'd0);
        tick(1);
        check("bounce_edge6_count", {250'd0, byte_count}, 256'd1);
        tick(20);
        check("bounce_single_accept", {250'd0, byte_count}, 256'd1);
        load_btn = 1'b0;
        tick(8);

        // key_sel switched mid-load is ignored
        key_sel = 2'b11;
        e.msg = {8'h5a, 120'd0};
        for (int i = 1; i < 16; i++) e.msg[127 - 8 * i -: 8] = 8'(8'hc0 + i);
        acc = '0;
        for (int i = 0; i < 16; i++) acc = {acc[247:0], 8'(8'h90 + i)};
        e.key = left_key(acc, 16);
        e.len = 2'b01;
        sb.push_back(e);
        for (int i = 1; i < 16; i++) press(8'(8'hc0 + i));
        for (int i = 0; i < 16; i++) press(8'(8'h90 + i));
        expect_block("ksw", 40);
        check("ksw_count", {250'd0, byte_count}, 256'd16);
        handshake();

        // key_sel=00 in IDLE: presses ignored; block_ready while idle is harmless
        key_sel = 2'b00;
        block_ready = 1'b1;
        for (int i = 0; i < 5; i++) press(8'(8'h10 + i));
        block_ready = 1'b0;
        check("ksel0_count", {250'd0, byte_count}, 256'd0);
        check("ksel0_busy", {255'd0, busy}, 256'd0);
        check("ksel0_valid", {255'd0, block_valid}, 256'd0);

        // Reset mid-load
        key_sel = 2'b01;
        for (int i = 0; i < 7; i++) press(8'(8'h70 + i));
        check("midrst_before_count", {250'd0, byte_count}, 256'd7);
        reset = 1'b0;
        #1;
        check("midrst_message", {128'd0, message}, 256'd0);
        check("midrst_count", {250'd0, byte_count}, 256'd0);
        check("midrst_busy", {255'd0, busy}, 256'd0);
        tick(2);
        reset = 1'b1;
        tick(2);
        press(8'ha5);
        check("postrst_first_byte", {128'd0, message}, {128'd0, 8'ha5, 120'd0});
        check("postrst_count", {250'd0, byte_count}, 256'd1);
        e.msg = {8'ha5, 120'd0};
        for (int i = 1; i < 16; i++) e.msg[127 - 8 * i -: 8] = 8'(8'h20 + i);
        acc = '0;
        for (int i = 0; i < 16; i++) acc = {acc[247:0], k128[15 - i]};
        e.key = left_key(acc, 16);
        e.len = 2'b01;
        sb.push_back(e);
        for (int i = 1; i < 16; i++) press(8'(8'h20 + i));
        for (int i = 0; i < 16; i++) press(k128[15 - i]);
        expect_block("postrst", 40);

        // Press coincident with the handshake edge is dropped
        data_in = 8'hee;
        load_btn = 1'b1;
        tick(5);
        block_ready = 1'b1;
        tick(1);
        block_ready = 1'b0;
        check("coinc_valid", {255'd0, block_valid}, 256'd0);
        check("coinc_count", {250'd0, byte_count}, 256'd0);
        check("coinc_busy", {255'd0, busy}, 256'd0);
        tick(10);
        load_btn = 1'b0;
        tick(10);
        check("coinc_after_count", {250'd0, byte_count}, 256'd0);
        check("sb_drained", {224'd0, 32'(sb.size())}, 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_input_loader.md
Name: aes_input_loader

Overview:
- Input-side counterpart to the cipher-to-display path: assembles a 128-bit plaintext block and a 128/192/256-bit key byte-by-byte from board switches and a pushbutton.
- Presents the assembled block to the encrypt/decrypt cores over a valid/ready handshake.
- Sits between the board switches/button and the keyExpansion/encrypt instances in the top level, replacing the fixed message and key constants.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a button press or release (board build uses 1000000)
SYNC_STAGES, 2, flip-flops in the button synchronizer

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
data_in  input  8  byte value from switches
load_btn  input  1  raw pushbutton, active-high after board inversion, asynchronous to clk
key_sel  input  2  key length: 01=128, 10=192, 11=256, 00=none
block_ready  input  1  consumer accepts block
message  output  128  assembled plaintext, byte 0 in [127:120]
key  output  256  assembled key, left-justified; byte 0 in [255:248]; unused low bytes zero
key_len  output  2  key_sel value latched at block start
block_valid  output  1  message/key complete and stable
busy  output  1  high in LOAD_MSG or LOAD_KEY
byte_count  output  6  bytes captured in current phase (for HEX display)

Behaviour:
- Reset (reset=0, async): message=0, key=0, key_len=00, block_valid=0, busy=0, byte_count=0, state=IDLE, debounce counter=0, accepted-level=0.
- Button path:
  - load_btn passes through SYNC_STAGES flops, then the debouncer.
  - A press is accepted at the clock edge where the synchronized level has been high for DEBOUNCE_CYCLES consecutive cycles: SYNC_STAGES+DEBOUNCE_CYCLES edges after the raw input rises.
  - Exactly one accept pulse per press.
  - A new press is eligible only after the level has been stable low for DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES produce no accept.
- Key byte total: NKB = 16, 24 or 32 for key_len 01, 10, 11.
- States IDLE, LOAD_MSG, LOAD_KEY, VALID:
  - IDLE:
    - accept with key_sel≠00: latch key_len=key_sel; clear message and key; write data_in to message[127:120]; byte_count=1; go to LOAD_MSG.
    - accept with key_sel=00: ignored.
    - message/key from the previous block are held for display until the next start.
  - LOAD_MSG:
    - each accept writes data_in to message byte byte_count (byte k at [127-8k -: 8]) and increments byte_count.
    - the accept writing byte 15 sets byte_count=0 and goes to LOAD_KEY.
  - LOAD_KEY:
    - each accept writes key byte byte_count (byte k at [255-8k -: 8]) and increments byte_count.
    - the accept writing byte NKB-1 sets byte_count=NKB, block_valid=1 and goes to VALID.
  - VALID:
    - block_valid held high; message, key and key_len stable.
    - at an edge with block_valid&block_ready: block_valid=0, byte_count=0, go to IDLE.
    - accepts are ignored, including one coincident with the handshake edge.
- busy=1 exactly in LOAD_MSG/LOAD_KEY.
- key_sel changes after start are ignored until the next IDLE start.
- block_ready high while not valid: no effect.
- Reset mid-load aborts; all outputs return to reset values.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package aes_pkg:
  - state encoding: IDLE=0, LOAD_MSG=1, LOAD_KEY=2, VALID=3
  - key_sel codes KEY128=2'b01, KEY192=2'b10, KEY256=2'b11
  - function mapping key code to NKB (16/24/32)
  - widths MSG_W=128, KEY_W=256
- One sub-module: button_debounce (synchronizer, stability counter, single-cycle accept pulse), parameterized by SYNC_STAGES and DEBOUNCE_CYCLES.

Test Plan:
- 128-bit load: key_sel=01; 32 clean presses with bytes 00,11,...,ff then 2b,7e,15,16,28,ae,d2,a6,ab,f7,15,88,09,cf,4f,3c; block_ready=0 -> block_valid=1 after the 32nd accept, message=00112233445566778899aabbccddeeff, key=2b7e151628aed2a6abf7158809cf4f3c followed by 128 zero bits, key_len=01, byte_count=16; valid held 20 cycles; block_ready=1 for one edge -> block_valid=0, IDLE, message/key unchanged.
- 192-bit load: key_sel=10; 16 message bytes plus 24 key bytes 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> valid after the 40th accept; key[255:64] matches; key[63:0]=0.
- Debounce: 3-cycle glitch on load_btn -> byte_count unchanged. Press toggling high/low every 2 cycles for 10 cycles then held high -> exactly one accept, at edge 2+4 after the final rise.
- key_sel=00 in IDLE with 5 presses -> state stays IDLE, byte_count=0. key_sel switched 01->11 mid-load -> key_len stays 01; valid after 32 total bytes.
- Reset pulled low after 7 message bytes -> same cycle: message=0, byte_count=0, busy=0. Next accepted press with key_sel=01 starts at message byte 0.
- In VALID, press coincident with the block_ready handshake edge -> press ignored; next state IDLE with byte_count=0 (not 1).
